// File: rtl/vl_strip_ctrl.sv
// Strip-mining sequencer: turns one (SEW, LMUL, AVL) request into a series of
// vl-sized strips. Optional strip counters are built when VL_STRIP_CNT_EN is defined.
module vl_strip_ctrl #(
    parameter int VLEN  = 128,
    parameter int AVL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_sew,
    input  logic [2:0]       cfg_lmul,
    input  logic [AVL_W-1:0] cfg_avl,
    output logic             strip_valid,
    input  logic             strip_ready,
    output logic [AVL_W-1:0] strip_vl,
    output logic             strip_last,
    output logic [AVL_W-1:0] vlmax,
`ifdef VL_STRIP_CNT_EN
    output logic [7:0]       strip_idx,
    output logic [7:0]       strip_total,
`endif
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE, S_ERR} state_t;

    localparam logic [31:0] VL_SAT = (32'd1 << AVL_W) - 32'd1;

    state_t           state_q;
    logic [2:0]       sew_q, lmul_q;
    logic [AVL_W-1:0] rem_q, vlmax_q, strip_vl_q;
    logic             cfg_ready_q, strip_valid_q, strip_last_q, busy_q, done_q, cfg_err_q;

    logic [31:0]      base_w, prod_w;
    logic [AVL_W-1:0] vlmax_d, first_vl_d, rem_d, next_vl_d;

    // VLMAX is formed wide and saturated so large LMUL never wraps the bus
    always_comb begin
        base_w     = 32'(VLEN) >> ({29'd0, sew_q} + 32'd3);
        prod_w     = base_w << lmul_q;
        vlmax_d    = (prod_w > VL_SAT) ? VL_SAT[AVL_W-1:0] : prod_w[AVL_W-1:0];
        first_vl_d = (rem_q < vlmax_d) ? rem_q : vlmax_d;
        rem_d      = rem_q - strip_vl_q;
        next_vl_d  = (rem_d < vlmax_q) ? rem_d : vlmax_q;
    end

`ifdef VL_STRIP_CNT_EN
    logic [7:0]  idx_q, total_q;
    logic [31:0] div_w, tot_w;
    always_comb begin
        div_w = (vlmax_d == '0) ? 32'd1 : 32'(vlmax_d);
        tot_w = (32'(rem_q) + div_w - 32'd1) / div_w;
    end
    assign strip_idx   = idx_q;
    assign strip_total = total_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sew_q         <= '0;
            lmul_q        <= '0;
            rem_q         <= '0;
            vlmax_q       <= '0;
            strip_vl_q    <= '0;
            cfg_ready_q   <= 1'b1;
            strip_valid_q <= 1'b0;
            strip_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
`ifdef VL_STRIP_CNT_EN
            idx_q         <= '0;
            total_q       <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid) begin
                        sew_q       <= cfg_sew;
                        lmul_q      <= cfg_lmul;
                        rem_q       <= cfg_avl;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cfg_sew > 3'd4 || cfg_lmul > 3'd4) begin
                            state_q   <= S_ERR;
                            cfg_err_q <= 1'b1;
                            vlmax_q   <= '0;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
`ifdef VL_STRIP_CNT_EN
                    idx_q   <= '0;
                    total_q <= (tot_w > 32'd255) ? 8'd255 : tot_w[7:0];
`endif
                    if (base_w == '0) begin
                        state_q   <= S_ERR;
                        cfg_err_q <= 1'b1;
                        vlmax_q   <= '0;
                    end else if (rem_q == '0) begin
                        state_q <= S_DONE;
                        vlmax_q <= vlmax_d;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= S_ISSUE;
                        vlmax_q       <= vlmax_d;
                        strip_valid_q <= 1'b1;
                        strip_vl_q    <= first_vl_d;
                        strip_last_q  <= (rem_q <= vlmax_d);
                    end
                end
                S_ISSUE: begin
                    if (strip_ready) begin
                        rem_q <= rem_d;
`ifdef VL_STRIP_CNT_EN
                        idx_q <= idx_q + 8'd1;
`endif
                        if (strip_last_q) begin
                            state_q       <= S_DONE;
                            done_q        <= 1'b1;
                            strip_valid_q <= 1'b0;
                            strip_vl_q    <= '0;
                            strip_last_q  <= 1'b0;
                        end else begin
                            strip_vl_q   <= next_vl_d;
                            strip_last_q <= (rem_d <= vlmax_q);
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign strip_valid = strip_valid_q;
    assign strip_vl    = strip_vl_q;
    assign strip_last  = strip_last_q;
    assign vlmax       = vlmax_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vl_strip_ctrl.sv
// Scoreboard bench for vl_strip_ctrl: expected strips are queued from a small
// model when a request is issued and popped on every strip handshake.
module tb_vl_strip_ctrl;
    localparam int VLEN  = 128;
    localparam int AVL_W = 9;

    logic             clk = 1'b0, rst = 1'b1;
    logic             cfg_valid = 1'b0, strip_ready = 1'b1;
    logic [2:0]       cfg_sew = '0, cfg_lmul = '0;
    logic [AVL_W-1:0] cfg_avl = '0;
    logic             cfg_ready, strip_valid, strip_last, busy, done, cfg_err;
    logic [AVL_W-1:0] strip_vl, vlmax;
`ifdef VL_STRIP_CNT_EN
    logic [7:0]       strip_idx, strip_total;
`endif

    int total = 0, bad = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    vl_strip_ctrl #(.VLEN(VLEN), .AVL_W(AVL_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul), .cfg_avl(cfg_avl),
        .strip_valid(strip_valid), .strip_ready(strip_ready),
        .strip_vl(strip_vl), .strip_last(strip_last), .vlmax(vlmax),
`ifdef VL_STRIP_CNT_EN
        .strip_idx(strip_idx), .strip_total(strip_total),
`endif
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_strip_valid", int'(strip_valid), 0);
        chk("rst_strip_vl", int'(strip_vl), 0);
        chk("rst_strip_last", int'(strip_last), 0);
        chk("rst_vlmax", int'(vlmax), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
    endtask

    // One request from the negedge it is driven until cfg_ready returns.
    // rst_at >= 0 asserts reset when that strip index is on the bus.
    task automatic run(input int sew, input int lmul, input int avl,
                       input int stall_n, input int rst_at);
        int  vm, rem, nexp, first_v, done_at, err_at, rdy_at, stalls, strips, ndone, w, e;
        bit  exp_err;
        logic pv, pr, plast;
        logic [AVL_W-1:0] pvl;
        vm = 0; nexp = 0; exp_err = (sew > 4) || (lmul > 4);
        if (!exp_err) begin
            vm = (VLEN >> (3 + sew)) << lmul;
            if ((VLEN >> (3 + sew)) == 0) exp_err = 1;
            if (vm > (1 << AVL_W) - 1) vm = (1 << AVL_W) - 1;
        end
        sb_q.delete();
        if (!exp_err) begin
            rem = avl;
            while (rem > 0) begin
                w = (rem < vm) ? rem : vm;
                sb_q.push_back(((rem <= vm) ? 1 << 16 : 0) | w);
                rem -= w;
                nexp++;
            end
        end
        w = 0;
        while (!cfg_ready && w < 50) begin @(negedge clk); w++; end
        if (!cfg_ready) chk("wait_idle_timeout", 0, 1);
        cfg_valid = 1'b1;
        cfg_sew   = 3'(sew);
        cfg_lmul  = 3'(lmul);
        cfg_avl   = AVL_W'(avl);
        @(posedge clk);
        first_v = -1; done_at = -1; err_at = -1; rdy_at = -1;
        stalls = 0; strips = 0; ndone = 0;
        pv = 0; pr = 0; pvl = '0; plast = 0;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            cfg_sew   = 3'($urandom_range(0, 7));
            cfg_avl   = AVL_W'($urandom);
            if (strip_valid && first_v < 0) first_v = n;
            if (done) begin done_at = n; ndone++; end
            if (cfg_err) begin
                err_at = n;
                chk("err_vlmax", int'(vlmax), 0);
            end
            if (cfg_ready) begin rdy_at = n; break; end
            if (pv && !pr) begin
                chk("hold_valid", int'(strip_valid), 1);
                chk("hold_vl", int'(strip_vl), int'(pvl));
                chk("hold_last", int'(strip_last), int'(plast));
            end
            if (strip_valid && strips == rst_at) begin
                rst = 1'b1;
                #1;
                chk_reset_vals();
                @(negedge clk);
                chk("rst_no_done", int'(done), 0);
                rst = 1'b0;
                strip_ready = 1'b1;
                sb_q.delete();
                return;
            end
            if (strip_valid) begin
                chk("vl_nonzero", int'(strip_vl != '0), 1);
`ifdef VL_STRIP_CNT_EN
                chk("strip_idx", int'(strip_idx), strips & 255);
                chk("strip_total", int'(strip_total), (nexp > 255) ? 255 : nexp);
`endif
                strip_ready = (stalls >= stall_n);
                if (!strip_ready) stalls++;
            end else begin
                strip_ready = n[0];
            end
            if (strip_valid && strip_ready) begin
                if (sb_q.size() == 0) chk("extra_strip", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("strip_vl", int'(strip_vl), e & 16'hffff);
                    chk("strip_last", int'(strip_last), e >> 16);
                end
                strips++;
            end
            pv = strip_valid; pr = strip_ready; pvl = strip_vl; plast = strip_last;
        end
        strip_ready = 1'b1;
        if (rdy_at < 0) chk("run_timeout", 0, 1);
        chk("vlmax_hold", int'(vlmax), exp_err ? 0 : vm);
        chk("missing_strips", sb_q.size(), 0);
        chk("strip_count", strips, nexp);
        if (exp_err) begin
            chk("err_at", err_at, 1);
            chk("err_no_done", ndone, 0);
            chk("err_ready_at", rdy_at, 2);
        end else begin
            chk("no_err", err_at, -1);
            chk("first_valid_at", first_v, (nexp > 0) ? 2 : -1);
            chk("done_count", ndone, 1);
            chk("done_at", done_at, nexp + 2 + ((nexp > 0) ? stall_n : 0));
            chk("ready_at", rdy_at, done_at + 1);
        end
    endtask

    initial begin
        @(negedge clk);
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(cfg_ready), 1);
        chk("idle_busy", int'(busy), 0);
        run(2, 1, 20, 0, -1);    // vlmax 8: 8,8,4
        run(0, 4, 300, 3, -1);   // vlmax 256 with first strip stalled
        run(1, 0, 0, 0, -1);     // zero AVL: no strips
        run(5, 0, 10, 0, -1);    // illegal SEW
        run(2, 0, 5, 0, -1);     // legal straight after the error
        run(0, 7, 10, 0, -1);    // illegal LMUL
        run(4, 0, 3, 0, -1);     // vlmax 1
        run(2, 1, 20, 0, 1);     // reset on the second strip
        run(1, 2, 50, 0, -1);    // clean restart, vlmax 32
        run(0, 4, 511, 1, -1);   // max AVL
        for (int i = 0; i < 6; i++)
            run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 511),
                $urandom_range(0, 2), -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
